// File: rtl/display_share_arbiter.sv
// Eight-way request arbiter sharing one 7-segment display.
// The granted index is shown as a digit; the dp lights when idle.
module display_share_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [2:0]       grant_idx,
    output logic             timeout,
    output logic [6:0]       segments,
    output logic             none
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [HOLD_W-1:0] hold_q;
    logic [N_REQ-1:0]  grant_q;
    logic [2:0]        idx_q;
    logic              valid_q;
    logic              timeout_q;
    logic [6:0]        seg_q;
    logic              none_q;

    logic [2:0] fix_k;
    logic [2:0] rr_k;
    logic [2:0] scan;
    logic [2:0] win_d;
    logic       rr_hit;
    logic       at_limit;

    function automatic logic [6:0] digit(input logic [2:0] d);
        logic [6:0] s;
        unique case (d)
            3'd0: s = 7'b0111111;
            3'd1: s = 7'b0000110;
            3'd2: s = 7'b1011011;
            3'd3: s = 7'b1001111;
            3'd4: s = 7'b1100110;
            3'd5: s = 7'b1101101;
            3'd6: s = 7'b1111101;
            default: s = 7'b0000111;
        endcase
        return s;
    endfunction

    // Round-robin scans downward from ptr with natural 3-bit wrap.
    always_comb begin
        fix_k  = '0;
        rr_k   = '0;
        rr_hit = 1'b0;
        scan   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) fix_k = 3'(i);
            scan = ptr_q - 3'(i);
            if (!rr_hit && req[scan]) begin
                rr_k   = scan;
                rr_hit = 1'b1;
            end
        end
        win_d = rr_mode ? rr_k : fix_k;
    end

    assign at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd7;
            hold_q    <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            seg_q     <= '0;
            none_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (|req) begin
                        state_q <= GRANT;
                        grant_q <= N_REQ'(1) << win_d;
                        idx_q   <= win_d;
                        valid_q <= 1'b1;
                        hold_q  <= '0;
                        ptr_q   <= win_d - 3'd1;
                        seg_q   <= digit(win_d);
                        none_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    hold_q <= hold_q + 1'b1;
                    if (!req[idx_q] || at_limit) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        valid_q   <= 1'b0;
                        seg_q     <= '0;
                        none_q    <= 1'b1;
                        // A drop coinciding with the limit is a normal release.
                        timeout_q <= req[idx_q];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign timeout     = timeout_q;
    assign segments    = seg_q;
    assign none        = none_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with a 4-cycle hold limit.
// Outputs are compared as one bundle {grant,valid,idx,timeout,seg,dp}.
module tb_display_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_mode;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout;
    logic [6:0] segments;
    logic       none;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] dig [8] = '{7'b0111111, 7'b0000110, 7'b1011011,
                            7'b1001111, 7'b1100110, 7'b1101101,
                            7'b1111101, 7'b0000111};

    always #5 clk = ~clk;

    display_share_arbiter #(
        .N_REQ(8), .MAX_HOLD(4), .HOLD_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_mode(rr_mode),
        .grant(grant), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .timeout(timeout),
        .segments(segments), .none(none)
    );

    logic [20:0] obs;
    assign obs = {grant, grant_valid, grant_idx, timeout, segments, none};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] exp;
        rst_n = 1'b0; req = 8'hFF; rr_mode = 1'b1;
        tick(); tick();
        exp = {8'h00, 1'b0, 3'd0, 1'b0, 7'b0000000, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", obs, exp);
        end
        rst_n = 1'b1;
        tick();
        exp = {8'h80, 1'b1, 3'd7, 1'b0, 7'b0000111, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL first_grant: got %h want %h", obs, exp);
        end
        req = 8'h00;
        tick();
        exp = {8'h00, 1'b0, 3'd7, 1'b0, 7'b0000000, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL first_release: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_fixed();
        logic [20:0] exp;
        rr_mode = 1'b0; req = 8'h14;
        tick();
        exp = {8'h10, 1'b1, 3'd4, 1'b0, 7'b1100110, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL fixed_grant: got %h want %h", obs, exp);
        end
        req = 8'h04;
        tick();
        exp = {8'h00, 1'b0, 3'd4, 1'b0, 7'b0000000, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL fixed_release: got %h want %h", obs, exp);
        end
        tick();
        exp = {8'h04, 1'b1, 3'd2, 1'b0, 7'b1011011, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL fixed_handover: got %h want %h", obs, exp);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_rr_rotation();
        logic [20:0] exp;
        int          e;
        do_reset();
        rr_mode = 1'b1; req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            e = (7 - n) & 7;
            for (int c = 0; c < 4; c++) begin
                tick();
                exp = {8'h01 << e, 1'b1, 3'(e), 1'b0, dig[e], 1'b0};
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL rr_hold n=%0d c=%0d: got %h want %h",
                             n, c, obs, exp);
                end
            end
            tick();
            exp = {8'h00, 1'b0, 3'(e), 1'b1, 7'b0000000, 1'b1};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rr_timeout n=%0d: got %h want %h",
                         n, obs, exp);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_fairness();
        int seq [7] = '{7, 0, 7, 0, 7, 7, 7};
        int e;
        do_reset();
        rr_mode = 1'b1; req = 8'h81;
        for (int n = 0; n < 7; n++) begin
            if (n == 4) rr_mode = 1'b0;
            e = seq[n];
            tick();
            n_cmp++;
            if (grant !== (8'h01 << e) || grant_idx !== 3'(e)) begin
                n_bad++;
                $display("FAIL fair n=%0d: got %h/%0d want %h/%0d",
                         n, grant, grant_idx, 8'h01 << e, e);
            end
            tick(); tick(); tick(); tick();
            n_cmp++;
            if (grant !== 8'h00 || timeout !== 1'b1) begin
                n_bad++;
                $display("FAIL fair_to n=%0d: got %h/%b want 00/1",
                         n, grant, timeout);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_idle_edge();
        logic [20:0] exp;
        do_reset();
        rr_mode = 1'b0; req = 8'h00;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (grant !== 8'h00 || none !== 1'b1 || timeout !== 1'b0 ||
                grant_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle c=%0d: got %h/%b/%b want 00/1/0",
                         c, grant, none, timeout);
            end
        end
        req = 8'h08;
        tick();
        exp = {8'h08, 1'b1, 3'd3, 1'b0, 7'b1001111, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL edge_grant: got %h want %h", obs, exp);
        end
        tick(); tick(); tick();
        req = 8'h00;
        tick();
        exp = {8'h00, 1'b0, 3'd3, 1'b0, 7'b0000000, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL edge_release: got %h want %h", obs, exp);
        end
        tick();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL edge_after: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] exp;
        rr_mode = 1'b0; req = 8'h20;
        tick();
        exp = {8'h20, 1'b1, 3'd5, 1'b0, 7'b1101101, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_grant: got %h want %h", obs, exp);
        end
        tick();
        rst_n = 1'b0;
        tick();
        exp = {8'h00, 1'b0, 3'd0, 1'b0, 7'b0000000, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_reset: got %h want %h", obs, exp);
        end
        rst_n = 1'b1; rr_mode = 1'b1; req = 8'h21;
        tick();
        exp = {8'h20, 1'b1, 3'd5, 1'b0, 7'b1101101, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_rr_pick: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 8'h00; rr_mode = 1'b0;
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_fairness();
        test_idle_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Shares one 7-segment display, and the 8-input index encoding that drives it, among 8 requesters.
- Each requester raises a level request. The block grants one requester at a time, in fixed or round-robin priority, and shows the granted index on the display.
- Grants are released when the owner drops its request or when a hold timeout expires.
- Sits between requesting agents and the display pins (segments on uo_out[6:0], dp on uo_out[7] at top level).

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8: the index is 3 bits and the display shows digits 0-7.
- MAX_HOLD, 15, maximum consecutive GRANT cycles before forced release. 0 disables the timeout.
- HOLD_W, 4, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- req  in  8  request levels; bit i = requester i
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (bit 7 highest); sampled only at arbitration
- grant  out  8  one-hot grant, registered
- grant_valid  out  1  high while any grant is active
- grant_idx  out  3  index of current or most recent grant
- timeout  out  1  one-cycle pulse on forced release
- segments  out  7  gfedcba, registered
- none  out  1  decimal point; high when no grant is active

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - segments=0000000, none=1, ptr=7, hold_cnt=0.
  - Reset mid-grant applies at that edge; no timeout pulse is generated.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner k, and at the next edge: state=GRANT, grant=1<<k, grant_idx=k, grant_valid=1, hold_cnt=0.
  - Latency is 1 cycle from sampled req to grant.
- Winner selection, fixed mode: highest set bit of req.
- Winner selection, round-robin mode: first set bit found scanning downward from ptr, wrapping 0->7.
- ptr update: on each grant to k, ptr <= (k-1) mod 8. ptr updates in both modes.
  - After reset, ptr=7, so the first round-robin pick equals the fixed pick.
- GRANT:
  - hold_cnt increments every cycle in GRANT.
  - Release when req[k]==0 is sampled, or when MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and req[k]==1 (timeout).
  - On release, at the next edge: state=IDLE, grant=0, grant_valid=0. grant_idx holds its value.
  - A timeout release also sets timeout=1 for exactly that IDLE cycle.
  - Requests from other requesters are ignored during GRANT.
- A granted requester holds the grant for at most MAX_HOLD cycles.
- Every release is followed by at least one IDLE cycle with grant=0. That cycle is the arbitration cycle, so back-to-back grants are separated by exactly one IDLE cycle.
- If req[k] drops and the hold limit is reached in the same cycle, treat it as a normal release: timeout=0.
- Display, registered alongside grant:
  - In GRANT: segments=digit(k), none=0.
  - In IDLE: segments=0000000, none=1.
- Digit table (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
- Invariants: grant is always one-hot or zero; grant_valid == |grant; none == ~grant_valid.

Test Plan:
- Reset and first grant: rst_n=0 for 2 cycles with req=FF → grant=00, none=1, segments=0000000. Release rst_n with rr_mode=1 → 1 cycle later grant=80, grant_idx=7, segments=0000111, none=0.
- Fixed priority and handover: rr_mode=0, req=14 → grant=10, segments=1100110. Clear req[4] → next cycle grant=00, none=1. Following cycle grant=04, segments=1011011.
- Round-robin timeout rotation: MAX_HOLD=4, rr_mode=1, req=FF held →
  - grants run 7,6,5,4,3,2,1,0,7.
  - Each grant lasts 4 cycles, separated by 1 IDLE cycle with timeout=1.
  - Indices stay one-hot and no index is skipped.
- Fairness versus fixed: req=81 held, MAX_HOLD=4. rr_mode=1 → grants alternate 7,0,7,0. rr_mode=0 → grant stays 7 on every regrant.
- Idle and simultaneous edge: req=00 for 20 cycles → grant=00, none=1, timeout=0 throughout. Drop req[k] on the cycle hold_cnt==MAX_HOLD-1 → release with timeout=0.
- Reset mid-grant: assert rst_n=0 during a grant to 5 → next edge grant=00, segments=0000000, none=1, timeout=0. After reset, a round-robin pick with req=21 selects 5.
